// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch stage and its IF/ID register.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'h0000_0003;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or insert a NOP bubble.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    // Bubble wins over load; neither asserted means hold.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bubble_i) begin
            pc_d    = pc_i;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC sequencing, stall/redirect handling, IF/ID capture.
// Define FETCH_MISALIGN_CHECK_EN to halt on a misaligned redirect target.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_valid,
    output logic            fetch_misalign,
    output logic [XLEN-1:0] fetch_count,
    output fetch_state_e    dbg_state
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] count_q, count_d;
    fetch_state_e    state_q, state_d;
    logic            ifid_load;
    logic            ifid_bubble;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
`endif

    // Priority inside RUN: redirect > stall > advance (rst handled in the flops).
    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        state_d     = state_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d        = redirect_pc & ~ALIGN_MASK;
                    ifid_bubble = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if ((redirect_pc & ALIGN_MASK) != '0) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end
`endif
                end else if (!stall) begin
                    pc_d      = pc_q + 32'd4;
                    count_d   = count_q + 32'd1;
                    ifid_load = 1'b1;
                end
            end
            // The redirect into HALT already left a bubble in IF/ID, so holding keeps it.
            HALT: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc_i     (pc_q),
        .instr_i  (imem_data),
        .pc_o     (if_pc),
        .instr_o  (if_instr),
        .valid_o  (if_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_count = count_q;
    assign dbg_state   = state_q;

endmodule
